// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - decode-stage RAW interlock and halt drain sequencer
//
// Tracks the destination register of each in-flight instruction from EX to WB.
// Stalls decode on read-after-write hazards and sequences the HALT drain.
//
// Optional feature macro: HAZARD_FORWARD_EN
//   defined   - an EX/MEM forwarding network exists; only load-use in EX stalls
//   undefined - full interlock against every stage except WB
//
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   id_valid        valid instruction present in ID
//   id_rs_used/rs   first source register read and its select
//   id_rt_used/rt   second source register read and its select
//   id_wr_en/reg    instruction writes the register file, destination select
//   id_is_load      instruction is a memory load
//   id_halt         instruction is HALT/createdump
//   ex_flush        taken branch/jump in EX squashes ID and EX
//   stall           hold PC and IF/ID, insert a bubble into ID/EX
//   issue           ID instruction advances into EX this cycle
//   pipe_busy       some tracked stage holds a valid write
//   halted          drain complete, sticky until rst
//   stall_cnt       saturating count of RAW stall cycles
//   err             registered flag: id_valid seen while halted
module hazard_scoreboard #(
    parameter int DEPTH = 3,
    parameter int REG_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic             id_rs_used,
    input  logic [REG_W-1:0] id_rs,
    input  logic             id_rt_used,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_wr_en,
    input  logic [REG_W-1:0] id_wr_reg,
    input  logic             id_is_load,
    input  logic             id_halt,
    input  logic             ex_flush,
    output logic             stall,
    output logic             issue,
    output logic             pipe_busy,
    output logic             halted,
    output logic [15:0]      stall_cnt,
    output logic             err
);

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_DRAIN  = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t state, state_nxt;

    // Stage 0 = EX, 1 = MEM, DEPTH-1 = WB
    logic [DEPTH-1:0]            ent_v;
    logic [DEPTH-1:0]            ent_ld;
    logic [DEPTH-1:0]            ent_hlt;
    logic [DEPTH-1:0][REG_W-1:0] ent_reg;

    logic rs_match;
    logic rt_match;
    logic raw;
    logic run;
    logic drain_done;

    // Bits that are carried along the pipe but never consulted
    logic unused_bits;
    assign unused_bits = ^{ent_ld, ent_hlt[DEPTH-1], ent_reg[DEPTH-1]};

`ifdef HAZARD_FORWARD_EN
    // Forwarding covers everything except a load whose data is not back yet
    always_comb begin
        rs_match = ent_v[0] && ent_ld[0] && (ent_reg[0] == id_rs);
        rt_match = ent_v[0] && ent_ld[0] && (ent_reg[0] == id_rt);
    end
`else
    // WB is excluded: the bypassed register file already shows its write
    always_comb begin
        rs_match = 1'b0;
        rt_match = 1'b0;
        for (int i = 0; i < DEPTH - 1; i++) begin
            if (ent_v[i] && (ent_reg[i] == id_rs)) rs_match = 1'b1;
            if (ent_v[i] && (ent_reg[i] == id_rt)) rt_match = 1'b1;
        end
    end
`endif

    assign raw       = (id_rs_used && rs_match) || (id_rt_used && rt_match);
    assign run       = (state == S_RUN);
    assign stall     = id_valid && ((run && raw && !ex_flush) || !run);
    assign issue     = id_valid && run && !raw && !ex_flush;
    assign pipe_busy = |ent_v;
    assign halted    = (state == S_HALTED);

    // The WB entry retires on this edge, so only the older stages decide
    // whether the pipe will be empty afterwards.
    assign drain_done = ~|(ent_v[DEPTH-2:0] | ent_hlt[DEPTH-2:0]);

    always_comb begin
        state_nxt = state;
        case (state)
            S_RUN: begin
                if (issue && id_halt) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (ex_flush && ent_hlt[0]) state_nxt = S_RUN;
                else if (drain_done)        state_nxt = S_HALTED;
            end
            S_HALTED: state_nxt = S_HALTED;
            default:  state_nxt = S_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ent_v   <= '0;
            ent_ld  <= '0;
            ent_hlt <= '0;
            ent_reg <= '0;
        end else begin
            // A halt never writes, it only marks its slot with hlt
            ent_v[0]   <= issue && id_wr_en && !id_halt;
            ent_reg[0] <= id_wr_reg;
            ent_ld[0]  <= issue && id_is_load;
            ent_hlt[0] <= issue && id_halt;
            for (int i = 1; i < DEPTH; i++) begin
                ent_v[i]   <= ent_v[i-1];
                ent_reg[i] <= ent_reg[i-1];
                ent_ld[i]  <= ent_ld[i-1];
                ent_hlt[i] <= ent_hlt[i-1];
            end
            // The squashed EX instruction must not reach MEM
            if (ex_flush) begin
                ent_v[1]   <= 1'b0;
                ent_ld[1]  <= 1'b0;
                ent_hlt[1] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            err       <= 1'b0;
        end else begin
            if (run && id_valid && raw && !ex_flush && (stall_cnt != 16'hFFFF)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
            err <= id_valid && (state == S_HALTED);
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - directed bench for hazard_scoreboard
module tb_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic        id_rs_used;
    logic [2:0]  id_rs;
    logic        id_rt_used;
    logic [2:0]  id_rt;
    logic        id_wr_en;
    logic [2:0]  id_wr_reg;
    logic        id_is_load;
    logic        id_halt;
    logic        ex_flush;
    logic        stall;
    logic        issue;
    logic        pipe_busy;
    logic        halted;
    logic [15:0] stall_cnt;
    logic        err;

    int checks = 0;
    int errors = 0;

    hazard_scoreboard #(.DEPTH(3), .REG_W(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .id_valid   (id_valid),
        .id_rs_used (id_rs_used),
        .id_rs      (id_rs),
        .id_rt_used (id_rt_used),
        .id_rt      (id_rt),
        .id_wr_en   (id_wr_en),
        .id_wr_reg  (id_wr_reg),
        .id_is_load (id_is_load),
        .id_halt    (id_halt),
        .ex_flush   (ex_flush),
        .stall      (stall),
        .issue      (issue),
        .pipe_busy  (pipe_busy),
        .halted     (halted),
        .stall_cnt  (stall_cnt),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic rsu, input logic [2:0] rs,
                         input logic rtu, input logic [2:0] rt,
                         input logic we, input logic [2:0] wr,
                         input logic ld, input logic hlt, input logic fl);
        id_valid   = v;
        id_rs_used = rsu;
        id_rs      = rs;
        id_rt_used = rtu;
        id_rt      = rt;
        id_wr_en   = we;
        id_wr_reg  = wr;
        id_is_load = ld;
        id_halt    = hlt;
        ex_flush   = fl;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1;
        idle();
        #12;
        chk("rst_stall",     32'(stall),     0);
        chk("rst_issue",     32'(issue),     0);
        chk("rst_pipe_busy", 32'(pipe_busy), 0);
        chk("rst_halted",    32'(halted),    0);
        chk("rst_stall_cnt", 32'(stall_cnt), 0);
        chk("rst_err",       32'(err),       0);
        rst = 1'b0;

        // ADDI r1 then ADD r2,r1,r3: two stall cycles
        drive(1, 1, 2, 0, 0, 1, 1, 0, 0, 0); #1;
        chk("t1_addi_issue", 32'(issue), 1);
        chk("t1_addi_stall", 32'(stall), 0);
        tick();
        drive(1, 1, 1, 1, 3, 1, 2, 0, 0, 0); #1;
        chk("t1_stall_c1", 32'(stall), 1);
        chk("t1_issue_c1", 32'(issue), 0);
        chk("t1_busy_c1",  32'(pipe_busy), 1);
        tick(); #1;
        chk("t1_stall_c2", 32'(stall), 1);
        tick(); #1;
        chk("t1_stall_c3", 32'(stall), 0);
        chk("t1_issue_c3", 32'(issue), 1);
        chk("t1_cnt",      32'(stall_cnt), 2);
        tick();

        // Source matches only the WB stage entry
        idle();
        tick();
        tick();
        drive(1, 1, 2, 0, 0, 0, 0, 0, 0, 0); #1;
        chk("t3_stall", 32'(stall), 0);
        chk("t3_issue", 32'(issue), 1);
        chk("t3_cnt",   32'(stall_cnt), 2);
        tick();

        // LD r4 then ADD r5,r4,r4 under full interlock
        drive(1, 0, 0, 0, 0, 1, 4, 1, 0, 0); #1;
        chk("t2_ld_issue", 32'(issue), 1);
        tick();
        drive(1, 1, 4, 1, 4, 1, 5, 0, 0, 0); #1;
        chk("t2_stall_c1", 32'(stall), 1);
        tick(); #1;
        chk("t2_stall_c2", 32'(stall), 1);
        tick(); #1;
        chk("t2_issue", 32'(issue), 1);
        chk("t2_cnt",   32'(stall_cnt), 4);
        tick();

        // HALT with two older writes in flight
        drive(1, 1, 0, 0, 0, 1, 6, 0, 0, 0); #1;
        chk("t4_w6_issue", 32'(issue), 1);
        tick();
        drive(1, 1, 0, 0, 0, 1, 7, 0, 0, 0); #1;
        chk("t4_w7_issue", 32'(issue), 1);
        tick();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0); #1;
        chk("t4_halt_issue", 32'(issue), 1);
        tick();
        drive(1, 1, 0, 0, 0, 1, 1, 0, 0, 0); #1;
        chk("t4_drain_stall",  32'(stall), 1);
        chk("t4_drain_issue",  32'(issue), 0);
        chk("t4_drain_halted", 32'(halted), 0);
        chk("t4_drain_busy",   32'(pipe_busy), 1);
        tick();
        idle(); #1;
        chk("t4_halted_c2", 32'(halted), 0);
        tick(); #1;
        chk("t4_halted_c3", 32'(halted), 0);
        chk("t4_busy_c3",   32'(pipe_busy), 0);
        tick();
        drive(1, 1, 0, 0, 0, 1, 1, 0, 0, 0); #1;
        chk("t4_halted", 32'(halted), 1);
        chk("t4_h_stall", 32'(stall), 1);
        chk("t4_h_issue", 32'(issue), 0);
        chk("t4_err_pre", 32'(err), 0);
        chk("t4_cnt",     32'(stall_cnt), 4);
        tick(); #1;
        chk("t4_err", 32'(err), 1);

        rst = 1'b1; #1;
        chk("rst2_halted", 32'(halted), 0);
        chk("rst2_err",    32'(err), 0);
        rst = 1'b0;
        idle();
        tick();

        // Flush while HALT sits in EX
        drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0); #1;
        chk("t5_halt_issue", 32'(issue), 1);
        tick();
        drive(1, 1, 0, 0, 0, 1, 1, 0, 0, 1); #1;
        chk("t5_flush_issue", 32'(issue), 0);
        chk("t5_flush_stall", 32'(stall), 1);
        tick();
        drive(1, 1, 0, 0, 0, 1, 3, 0, 0, 0); #1;
        chk("t5_issue",  32'(issue), 1);
        chk("t5_halted", 32'(halted), 0);
        chk("t5_busy",   32'(pipe_busy), 0);
        tick();

        // Build a drain with writes in flight and a nonzero counter, then reset
        drive(1, 1, 3, 0, 0, 1, 4, 0, 0, 0); #1;
        chk("t6_stall_c1", 32'(stall), 1);
        tick(); #1;
        chk("t6_stall_c2", 32'(stall), 1);
        tick(); #1;
        chk("t6_issue", 32'(issue), 1);
        chk("t6_cnt",   32'(stall_cnt), 2);
        tick();
        drive(1, 1, 0, 0, 0, 1, 5, 0, 0, 0);
        tick();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        tick();
        idle(); #1;
        chk("t6_pre_busy", 32'(pipe_busy), 1);
        chk("t6_pre_cnt",  32'(stall_cnt), 2);
        #2;
        rst = 1'b1; #1;
        chk("t6_rst_busy",   32'(pipe_busy), 0);
        chk("t6_rst_halted", 32'(halted), 0);
        chk("t6_rst_cnt",    32'(stall_cnt), 0);
        chk("t6_rst_stall",  32'(stall), 0);
        rst = 1'b0;
        tick();
        drive(1, 1, 5, 0, 0, 1, 2, 0, 0, 0); #1;
        chk("t6_run_issue", 32'(issue), 1);
        tick();
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
